// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the cycles-per-bit helper
// also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int cpb(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; 2-cycle latency, no backpressure.
// RST_VAL is the level both flops hold during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with 3-sample mid-bit majority vote; valid_out at T0+9*CPB+HALF+2.
// No backpressure: each byte or framing error is a one-cycle pulse the consumer must take.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       valid_out,
  output logic       framing_error_out,
  output logic       busy_out
);

  localparam int CPB  = cpb(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CYC_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CYC_S1   = CW'(HALF);
  localparam logic [CW-1:0] CYC_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CPB - 1);

  logic          w_rx_s;
  logic          r_rx_prev;
  rx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cyc, w_cyc_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic [1:0]    r_samp;
  logic          w_valid_nxt, w_ferr_nxt;
  logic          w_maj, w_decide, w_last;

  // Reset value 1 so a line already low at release still yields a falling edge.
  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_d     (rx_wire_in),
    .o_q     (w_rx_s)
  );

  assign w_decide = (r_cyc == CYC_DEC);
  assign w_last   = (r_cyc == CYC_LAST);
  assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
  assign busy_out = (r_state != IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state           <= IDLE;
      r_cyc             <= '0;
      r_bit_idx         <= '0;
      r_shift           <= '0;
      r_samp            <= '0;
      r_rx_prev         <= 1'b1;
      data_byte_out     <= '0;
      valid_out         <= 1'b0;
      framing_error_out <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_cyc             <= w_cyc_nxt;
      r_bit_idx         <= w_bit_idx_nxt;
      r_shift           <= w_shift_nxt;
      r_rx_prev         <= w_rx_s;
      data_byte_out     <= w_data_nxt;
      valid_out         <= w_valid_nxt;
      framing_error_out <= w_ferr_nxt;
      if (r_cyc == CYC_S0) r_samp[0] <= w_rx_s;
      if (r_cyc == CYC_S1) r_samp[1] <= w_rx_s;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = w_last ? '0 : r_cyc + CW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = data_byte_out;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cyc_nxt = '0;
        if (r_rx_prev && !w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (w_decide && w_maj) begin
          w_state_nxt = IDLE;
          w_cyc_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (w_decide) w_shift_nxt = {w_maj, r_shift[7:1]};
        if (w_last) begin
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at the stop-bit centre so a back-to-back start edge is not missed.
        if (w_decide) begin
          w_cyc_nxt = '0;
          if (w_maj) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_cyc_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed-stimulus bench for uart_receive: the whole pin/reset waveform is built up front,
// a frame-level model derives per-cycle expected outputs, and every cycle is compared.
module tb_uart_receive;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
  localparam int N         = 1400;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       rx_wire_in = 1'b1;
  logic [7:0] data_byte_out;
  logic       valid_out;
  logic       framing_error_out;
  logic       busy_out;

  uart_receive #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rx_wire_in        (rx_wire_in),
    .data_byte_out     (data_byte_out),
    .valid_out         (valid_out),
    .framing_error_out (framing_error_out),
    .busy_out          (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycle c is the interval after the c-th rising edge; pin[c]/rstv[c] are driven in it.
  logic       pin      [N];
  logic       rstv     [N];
  logic       exp_valid[N];
  logic       exp_ferr [N];
  logic       exp_busy [N];
  logic [7:0] exp_data [N];
  logic [7:0] byte_at  [N];
  int pos;
  int checks;
  int failures;
  int p_a5, p_b2b, p_glitch, p_ferr, p_spike, p_rst, p_42;

  task automatic put(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pin[pos] = v;
      pos++;
    end
  endtask

  task automatic put_bits(input logic [7:0] b);
    put(1'b0, CPB);
    for (int i = 0; i < 8; i++) put(b[i], CPB);
  endtask

  task automatic put_frame(input logic [7:0] b);
    put_bits(b);
    put(1'b1, CPB);
  endtask

  // Synchronised line as the receiver sees it: pin delayed two cycles, forced high around reset.
  function automatic logic rxs(input int c);
    if (c < 2 || c >= N) return 1'b1;
    if (!(rstv[c] && rstv[c-1] && rstv[c-2])) return 1'b1;
    return pin[c-2];
  endfunction

  // Majority of the three centre samples of bit k of a frame whose first START cycle is t0.
  function automatic logic bit_vote(input int t0, input int k);
    int ctr;
    int ones;
    ctr  = t0 + k * CPB + HALF;
    ones = int'(rxs(ctr - 1)) + int'(rxs(ctr)) + int'(rxs(ctr + 1));
    return ones >= 2;
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b && i < N; i++) if (!rstv[i]) return i;
    return -1;
  endfunction

  task automatic build_model();
    int c, t0, d, end_c, win, r, kind;
    logic [7:0] b;
    logic [7:0] held;
    for (int i = 0; i < N; i++) begin
      exp_valid[i] = 1'b0;
      exp_ferr[i]  = 1'b0;
      exp_busy[i]  = 1'b0;
      byte_at[i]   = 8'h00;
    end
    c = 1;
    while (c < N - 1) begin
      if (!rstv[c] || !(rxs(c - 1) && !rxs(c))) begin
        c++;
        continue;
      end
      t0 = c + 1;
      b  = 8'h00;
      d  = t0 + 9 * CPB + HALF + 1;
      if (bit_vote(t0, 0)) begin
        kind  = 0;
        end_c = t0 + HALF + 1;
        win   = end_c;
      end else begin
        for (int k = 0; k < 8; k++) b[k] = bit_vote(t0, k + 1);
        if (bit_vote(t0, 9)) begin
          kind  = 1;
          end_c = d;
          win   = d + 1;
        end else begin
          kind  = 2;
          end_c = d + 1;
          while (end_c < N - 1 && !rxs(end_c)) end_c++;
          win = end_c;
        end
      end
      r = first_rst(t0, win);
      if (r >= 0) begin
        for (int i = t0; i < r; i++) exp_busy[i] = 1'b1;
        c = r;
        continue;
      end
      for (int i = t0; i <= end_c && i < N; i++) exp_busy[i] = 1'b1;
      if (kind == 1 && d + 1 < N) begin
        exp_valid[d+1] = 1'b1;
        byte_at[d+1]   = b;
      end
      if (kind == 2 && d + 1 < N) exp_ferr[d+1] = 1'b1;
      c = end_c + 1;
    end
    held = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (!rstv[i]) held = 8'h00;
      else if (exp_valid[i]) held = byte_at[i];
      exp_data[i] = held;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, want);
    end
  endtask

  task automatic build_stimulus();
    for (int i = 0; i < N; i++) begin
      pin[i]  = 1'b1;
      rstv[i] = 1'b1;
    end
    for (int i = 0; i < 5; i++) rstv[i] = 1'b0;
    pos = 20;
    p_a5 = pos;      put_frame(8'hA5); put(1'b1, 30);
    p_b2b = pos;     put_frame(8'h00); put_frame(8'hFF); put_frame(8'h3C); put(1'b1, 30);
    p_glitch = pos;  put(1'b0, 3); put(1'b1, 40);
    p_ferr = pos;    put_bits(8'h55); put(1'b0, 60); put(1'b1, 40);
    p_spike = pos;   put_frame(8'hF0); put(1'b1, 30);
    pin[p_spike + 46] = 1'b1;
    // Reset held until the line is back high (data bit 7 of 0x81) so no partial frame is resynced.
    p_rst = pos;     put_frame(8'h81); put(1'b1, 20);
    for (int i = p_rst + 43; i <= p_rst + 84; i++) rstv[i] = 1'b0;
    p_42 = pos;      put_frame(8'h42);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    build_stimulus();
    build_model();
    fork
      begin
        for (int c = 0; c < N; c++) begin
          @(posedge clk_in);
          #1;
          rst_in     = rstv[c];
          rx_wire_in = pin[c];
        end
      end
      begin
        for (int c = 0; c < N; c++) begin
          @(negedge clk_in);
          chk("valid", c, {7'd0, valid_out}, {7'd0, exp_valid[c]});
          chk("ferr",  c, {7'd0, framing_error_out}, {7'd0, exp_ferr[c]});
          chk("busy",  c, {7'd0, busy_out}, {7'd0, exp_busy[c]});
          chk("data",  c, data_byte_out, exp_data[c]);
          if (valid_out === 1'b1 && framing_error_out === 1'b1) chk("excl", c, 8'h01, 8'h00);
          if (c == 2) chk("rst_data", c, data_byte_out, 8'h00);
          if (c == p_a5 + 2)   chk("a5_busy_pre", c, {7'd0, busy_out}, 8'h00);
          if (c == p_a5 + 3)   chk("a5_busy_t0", c, {7'd0, busy_out}, 8'h01);
          if (c == p_a5 + 99)  chk("a5_busy_end", c, {7'd0, busy_out}, 8'h01);
          if (c == p_a5 + 99)  chk("a5_valid_early", c, {7'd0, valid_out}, 8'h00);
          if (c == p_a5 + 100) chk("a5_valid", c, {7'd0, valid_out}, 8'h01);
          if (c == p_a5 + 100) chk("a5_data", c, data_byte_out, 8'hA5);
          if (c == p_a5 + 100) chk("a5_busy_idle", c, {7'd0, busy_out}, 8'h00);
          if (c == p_b2b + 100) chk("b2b_0", c, data_byte_out, 8'h00);
          if (c == p_b2b + 200) chk("b2b_1", c, data_byte_out, 8'hFF);
          if (c == p_b2b + 300) chk("b2b_2", c, data_byte_out, 8'h3C);
          if (c == p_b2b + 300) chk("b2b_2_valid", c, {7'd0, valid_out}, 8'h01);
          if (c == p_glitch + 3)  chk("glitch_busy", c, {7'd0, busy_out}, 8'h01);
          if (c == p_glitch + 10) chk("glitch_idle", c, {7'd0, busy_out}, 8'h00);
          if (c == p_ferr + 100) chk("ferr_pulse", c, {7'd0, framing_error_out}, 8'h01);
          if (c == p_ferr + 100) chk("ferr_data_kept", c, data_byte_out, 8'h3C);
          if (c == p_ferr + 140) chk("ferr_wait_busy", c, {7'd0, busy_out}, 8'h01);
          if (c == p_spike + 100) chk("spike_data", c, data_byte_out, 8'hF0);
          if (c == p_rst + 43) chk("rst_mid_data", c, data_byte_out, 8'h00);
          if (c == p_rst + 43) chk("rst_mid_busy", c, {7'd0, busy_out}, 8'h00);
          if (c == p_42 + 100) chk("after_rst_data", c, data_byte_out, 8'h42);
          if (c == p_42 + 100) chk("after_rst_valid", c, {7'd0, valid_out}, 8'h01);
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- PC-to-FPGA UART receiver: the upstream counterpart of the board's transmit path. Serves the `uart_rxd` pin.
- Recovers 8N1 frames from the asynchronous serial line, LSB first.
- Presents each byte as a one-cycle valid pulse to the decryptor datapath; reports framing errors.
- Mid-bit 3-sample majority voting rejects glitches.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CPB (localparam), CLK_FREQ/BAUD_RATE with integer truncation (10416 at defaults), clock cycles per bit.
- HALF (localparam), CPB/2, mid-bit sample index; CPB must be ≥ 8.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset; asserted when 0.
- rx_wire_in  input  1  raw serial line, asynchronous to clk_in, idles high.
- data_byte_out  output  8  last received byte; holds until the next valid byte.
- valid_out  output  1  one-cycle pulse: data_byte_out is new.
- framing_error_out  output  1  one-cycle pulse: stop bit sampled low.
- busy_out  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset values (rst_in low, asynchronous): data_byte_out=0, valid_out=0, framing_error_out=0, busy_out=0, state=IDLE, synchronizer flops=1, counters=0.
- Input conditioning:
  - rx_wire_in passes through a 2-flop synchronizer reset to 1, giving rx_s.
  - All logic uses rx_s only; pin-to-rx_s latency is 2 cycles.
- Sampling:
  - cyc counts 0..CPB-1 within each bit period.
  - Samples are taken at cyc = HALF-1, HALF and HALF+1.
  - bit value = majority of the 3 samples.
  - The decision is made in the cycle cyc==HALF+1, using that cycle's rx_s as the third sample.
- State machine:
  - IDLE: on rx_s falling edge (previous rx_s=1, current rx_s=0) go to START with cyc=0; this cycle is T0.
  - START: on the decision, if majority=1 (glitch) go to IDLE with no output. Otherwise, at cyc==CPB-1 go to DATA with bit_idx=0, cyc=0.
  - DATA: on each decision, shift the bit into a shift register LSB first. At cyc==CPB-1: if bit_idx==7 go to STOP, else bit_idx+1.
  - STOP, decision majority=1: the next cycle sets data_byte_out=shift register and pulses valid_out for exactly 1 cycle, then goes to IDLE immediately (does not wait out the stop bit).
  - STOP, decision majority=0: data_byte_out is unchanged; pulse framing_error_out for 1 cycle, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held-low break line therefore produces exactly one error, not repeated frames.
- Latency: valid_out rises at T0 + 9*CPB + HALF + 2 cycles.
- Back-to-back frames:
  - IDLE is re-entered before the stop bit ends, so the next start edge is caught at its first rx_s low cycle.
  - There is no minimum gap beyond one stop bit.
- No backpressure: the consumer must accept on valid_out. A later byte overwrites data_byte_out.
- valid_out and framing_error_out are never high in the same cycle.
- Reset mid-frame: outputs and state return to reset values immediately; the partial byte is discarded. After release, a frame whose start edge is already past is not decoded. Reception resumes at the next falling edge seen from IDLE (the synchronizer reset of 1 ensures a low line produces an edge).

Decomposition:
- Package uart_pkg: state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}, plus the cycles-per-bit function cpb(clk, baud) shared with the transmitter.
- One sub-module, sync_2ff (parameterised reset value), reused for other asynchronous inputs such as buttons and cipo.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000 → CPB=10, HALF=5):
- Send 0xA5 with a correct stop bit → one valid_out pulse at T0+97, data_byte_out=0xA5, framing_error_out stays 0, busy_out high T0..T0+96.
- Send 0x00, 0xFF, 0x3C back-to-back with 1 stop bit each → three valid pulses in order with those values; no error.
- Glitch: rx low for 3 cycles only → no valid, no error; busy_out returns to 0 by T0+7.
- Stop bit low (byte 0x55 then line held low 50 cycles) → one framing_error_out pulse; data_byte_out keeps its previous value; no new frame until the line returns high and falls again.
- 1-cycle spike inverted at the centre of data bit 3 of 0xF0 → majority voting yields 0xF0.
- rst_in asserted at T0+40 during frame 0x81 → all outputs 0 immediately; no valid pulse; the next full frame 0x42 is received correctly.
